bram_image_store_mc: RTL and testbench

//  Parametrised multi-channel frame store: NUM_CH planes of IMG_W*IMG_H pixels in block RAM.

---
 rtl/img_store_pkg.sv | 15 +
 rtl/bram_image_store_mc_if.sv | 35 +++
 rtl/img_skid_buf.sv | 61 ++++++
 rtl/bram_image_store_mc.sv | 174 +++++++++++++++++
 tb/tb_bram_image_store_mc.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/img_store_pkg.sv
// Shared types and width helpers for the multi-channel BRAM frame store.
package img_store_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

  // Address/select width for n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_image_store_mc_if.sv
// Bus bundle of the frame store: write port, random read port and raster-scan stream.
interface bram_image_store_mc_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned NUM_CH = 3
);
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [CH_W-1:0]         wr_ch;
  logic [PIX_W-1:0]        wr_data;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [CH_W-1:0]         rd_ch;
  logic [PIX_W-1:0]        rd_data;
  logic                    rd_valid;
  logic                    scan_start;
  logic                    scan_busy;
  logic                    scan_done;
  logic [NUM_CH*PIX_W-1:0] scan_data;
  logic                    scan_valid;
  logic                    scan_ready;
  logic                    scan_sol;
  logic                    scan_last;

  modport master (
    output wr_en, wr_addr, wr_ch, wr_data, rd_en, rd_addr, rd_ch, scan_start, scan_ready,
    input  rd_data, rd_valid, scan_busy, scan_done, scan_data, scan_valid, scan_sol, scan_last
  );

  modport slave (
    input  wr_en, wr_addr, wr_ch, wr_data, rd_en, rd_addr, rd_ch, scan_start, scan_ready,
    output rd_data, rd_valid, scan_busy, scan_done, scan_data, scan_valid, scan_sol, scan_last
  );
endinterface

// File: rtl/img_skid_buf.sv
// Two-entry valid/ready skid buffer; space_c tells the producer a new item may be launched now.
module img_skid_buf #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             space_c,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [1:0]       occ, occ_nx;
  logic [WIDTH-1:0] ent0, ent1;
  logic             push, pop;

  assign push = in_valid;
  assign pop  = out_valid && out_ready;

  // Occupancy after this cycle; an item launched now lands next cycle.
  always_comb begin
    occ_nx = occ;
    case ({push, pop})
      2'b10:   if (occ != 2'd2) occ_nx = occ + 2'd1;
      2'b01:   occ_nx = occ - 2'd1;
      default: occ_nx = occ;
    endcase
  end

  assign space_c = (occ_nx < 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      ent0      <= '0;
      ent1      <= '0;
      out_valid <= 1'b0;
    end else begin
      occ       <= occ_nx;
      out_valid <= (occ_nx != 2'd0);
      case (occ)
        2'd0: if (push) ent0 <= in_data;
        2'd1: begin
          if (push && pop) ent0 <= in_data;
          else if (push)   ent1 <= in_data;
        end
        default: begin
          if (pop) begin
            ent0 <= ent1;
            if (push) ent1 <= in_data;
          end
        end
      endcase
    end
  end

  assign out_data = ent0;

endmodule

// File: rtl/bram_image_store_mc.sv
// Multi-channel frame store: per-channel BRAM planes, random read port and raster-scan stream engine.
module bram_image_store_mc
  import img_store_pkg::*;
#(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned PIX_W  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  bram_image_store_mc_if.slave bus
);

  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = clog2_min1(NPIX);
  localparam int unsigned CH_W   = clog2_min1(NUM_CH);
  localparam int unsigned XW     = clog2_min1(IMG_W);
  localparam int unsigned YW     = clog2_min1(IMG_H);
  localparam int unsigned DW     = NUM_CH * PIX_W;
  localparam int unsigned SW     = DW + 2;

  scan_state_e       state, state_nx;
  logic [ADDR_W-1:0] scan_addr, raddr;
  logic [XW-1:0]     scan_x;
  logic [YW-1:0]     scan_y;
  logic              x_end, addr_is_last;
  logic              issue_c, start_acc_c, last_pop_c;
  logic              issue_q, issue_sol_q, issue_last_q;
  logic              busy_q, done_q;
  logic [DW-1:0]     ram_pack;
  logic              space_c, skid_valid;
  logic [SW-1:0]     skid_out;
  logic              wr_addr_ok, wr_ch_ok, rd_addr_ok, rd_ch_ok, wr_fire, rd_fire;
  logic              rd_valid_q, rd_oob_q;
  logic [CH_W-1:0]   rd_ch_q;
  logic [PIX_W-1:0]  rd_sel;

  // Range checks collapse to constants when the field is exactly full.
  if (NPIX == (2 ** ADDR_W)) begin : g_addr_full
    assign wr_addr_ok = 1'b1;
    assign rd_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign wr_addr_ok = (bus.wr_addr < ADDR_W'(NPIX));
    assign rd_addr_ok = (bus.rd_addr < ADDR_W'(NPIX));
  end

  if (NUM_CH == (2 ** CH_W)) begin : g_ch_full
    assign wr_ch_ok = 1'b1;
    assign rd_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign wr_ch_ok = (bus.wr_ch < CH_W'(NUM_CH));
    assign rd_ch_ok = (bus.rd_ch < CH_W'(NUM_CH));
  end

  assign wr_fire = bus.wr_en && wr_addr_ok && wr_ch_ok;
  assign raddr   = busy_q ? scan_addr : bus.rd_addr;

  // One plane per channel; registered read gives read-first behaviour on collisions.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_plane
    logic [PIX_W-1:0] mem [NPIX];
    logic [PIX_W-1:0] q;
    always_ff @(posedge clk) begin
      if (wr_fire && (bus.wr_ch == CH_W'(k))) mem[bus.wr_addr] <= bus.wr_data;
      q <= mem[raddr];
    end
    assign ram_pack[k*PIX_W +: PIX_W] = q;
  end

  assign x_end        = (scan_x == XW'(IMG_W - 1));
  assign addr_is_last = x_end && (scan_y == YW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.scan_start) state_nx = RUN;
      RUN:     if (issue_c && addr_is_last) state_nx = DRAIN;
      DRAIN:   if (last_pop_c) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    issue_c     = 1'b0;
    start_acc_c = 1'b0;
    last_pop_c  = 1'b0;
    case (state)
      IDLE:    start_acc_c = bus.scan_start;
      RUN:     issue_c     = space_c;
      DRAIN:   last_pop_c  = skid_valid && bus.scan_ready && skid_out[SW-1];
      default: ;
    endcase
  end

  // Raster counters plus the sideband that travels alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_addr    <= '0;
      scan_x       <= '0;
      scan_y       <= '0;
      issue_q      <= 1'b0;
      issue_sol_q  <= 1'b0;
      issue_last_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      issue_q      <= issue_c;
      issue_sol_q  <= (scan_x == '0);
      issue_last_q <= addr_is_last;
      busy_q       <= (state_nx != IDLE);
      done_q       <= last_pop_c;
      if (start_acc_c) begin
        scan_addr <= '0;
        scan_x    <= '0;
        scan_y    <= '0;
      end else if (issue_c && !addr_is_last) begin
        scan_addr <= scan_addr + ADDR_W'(1);
        if (x_end) begin
          scan_x <= '0;
          scan_y <= scan_y + YW'(1);
        end else begin
          scan_x <= scan_x + XW'(1);
        end
      end
    end
  end

  img_skid_buf #(.WIDTH(SW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue_q),
    .in_data   ({issue_last_q, issue_sol_q, ram_pack}),
    .space_c   (space_c),
    .out_valid (skid_valid),
    .out_data  (skid_out),
    .out_ready (bus.scan_ready)
  );

  assign rd_fire = bus.rd_en && !busy_q && !start_acc_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_ch_q    <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      rd_oob_q   <= !(rd_addr_ok && rd_ch_ok);
      rd_ch_q    <= bus.rd_ch;
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch_q == CH_W'(k)) rd_sel = ram_pack[k*PIX_W +: PIX_W];
    end
  end

  assign bus.rd_data    = (rd_valid_q && !rd_oob_q) ? rd_sel : '0;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.scan_busy  = busy_q;
  assign bus.scan_done  = done_q;
  assign bus.scan_valid = skid_valid;
  assign bus.scan_data  = skid_out[DW-1:0];
  assign bus.scan_sol   = skid_out[DW];
  assign bus.scan_last  = skid_out[DW+1];

endmodule

// File: tb/tb_bram_image_store_mc.sv
// Directed bench for bram_image_store_mc on a 4x2, 3-channel, 8-bit frame.
module tb_bram_image_store_mc;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] pat = 16'b1011_0010_1101_0110;

  always #5 clk = ~clk;

  bram_image_store_mc_if #(.ADDR_W(3), .CH_W(2), .PIX_W(8), .NUM_CH(3)) bus ();

  bram_image_store_mc #(.IMG_W(4), .IMG_H(2), .NUM_CH(3), .PIX_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int k);
    return {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
  endfunction

  task automatic wr(input int a, input int ch, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = 3'(a); bus.wr_ch = 2'(ch); bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input int a, input int ch);
    bus.rd_en = 1'b1; bus.rd_addr = 3'(a); bus.rd_ch = 2'(ch);
    tick();
    bus.rd_en = 1'b0;
  endtask

  // mode 0: ready=1; mode 1: patterned ready; mode 2: ready=1 with rd_en/scan_start injected mid-scan
  task automatic collect(input int mode, input int stop_after);
    int nb, first_cyc, last_acc_cyc;
    bit done_seen, stall_prev;
    logic [25:0] held;
    nb = 0; first_cyc = -1; last_acc_cyc = -1; done_seen = 0; stall_prev = 0; held = '0;
    for (int cyc = 1; cyc <= 60 && !done_seen; cyc++) begin
      bus.scan_ready = (mode == 1) ? pat[cyc % 16] : 1'b1;
      if (mode == 2) begin
        bus.rd_en = (cyc == 2); bus.scan_start = (cyc == 2); bus.rd_addr = 3'd1; bus.rd_ch = 2'd0;
        chk("rd_drop_busy", 32'(bus.rd_valid), 32'd0);
      end
      if (stall_prev)
        chk("stall_hold", {bus.scan_valid, bus.scan_last, bus.scan_sol, bus.scan_data}, {1'b1, held});
      if (bus.scan_done) begin
        done_seen = 1;
        chk("done_after_last", cyc, last_acc_cyc + 1);
        chk("busy_fall", 32'(bus.scan_busy), 32'd0);
        chk("beat_count", nb, 8);
      end else if (bus.scan_valid && bus.scan_ready) begin
        chk("beat_data", 32'(bus.scan_data), 32'(pix(nb)));
        chk("beat_sol", 32'(bus.scan_sol), 32'((nb % 4) == 0));
        chk("beat_last", 32'(bus.scan_last), 32'(nb == 7));
        if (mode == 0 && nb > 0) chk("no_bubble", cyc, first_cyc + nb);
        if (nb == 0) first_cyc = cyc;
        last_acc_cyc = cyc;
        nb++;
      end
      stall_prev = bus.scan_valid && !bus.scan_ready;
      held = {bus.scan_last, bus.scan_sol, bus.scan_data};
      tick();
      if (stop_after > 0 && nb == stop_after) return;
    end
    bus.rd_en = 1'b0; bus.scan_start = 1'b0;
    chk("done_seen", 32'(done_seen), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_ch = 0; bus.wr_data = 0;
    bus.rd_en = 0; bus.rd_addr = 0; bus.rd_ch = 0;
    bus.scan_start = 0; bus.scan_ready = 0;
    tick(); tick();

    // reset values
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_busy", 32'(bus.scan_busy), 32'd0);
    chk("rst_done", 32'(bus.scan_done), 32'd0);
    chk("rst_valid", 32'(bus.scan_valid), 32'd0);
    chk("rst_data", 32'(bus.scan_data), 32'd0);
    chk("rst_sol_last", 32'({bus.scan_sol, bus.scan_last}), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. fill the frame and read one sample back
    for (int a = 0; a < 8; a++)
      for (int ch = 0; ch < 3; ch++) wr(a, ch, 8'(8'h10 * (ch + 1) + a));
    rd(5, 1);
    chk("rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("rd_data_a5c1", 32'(bus.rd_data), 32'h25);
    tick();
    chk("rd_valid_pulse", 32'(bus.rd_valid), 32'd0);

    // read-first on same-cycle write/read collision
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_ch = 2'd0; bus.wr_data = 8'h99;
    rd(2, 0);
    bus.wr_en = 1'b0;
    chk("read_first", 32'(bus.rd_data), 32'h12);
    rd(2, 0);
    chk("write_landed", 32'(bus.rd_data), 32'h99);
    wr(2, 0, 8'h12);

    // 2. illegal channel write ignored; out-of-range channel reads zero
    wr(1, 3, 8'hEE);
    rd(1, 0); chk("oob_wr_c0", 32'(bus.rd_data), 32'h11);
    rd(1, 1); chk("oob_wr_c1", 32'(bus.rd_data), 32'h21);
    rd(1, 2); chk("oob_wr_c2", 32'(bus.rd_data), 32'h31);
    rd(1, 3);
    chk("oob_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("oob_rd_data", 32'(bus.rd_data), 32'd0);

    // 3. full-rate scan
    bus.scan_start = 1'b1; tick(); bus.scan_start = 1'b0;
    chk("busy_after_start", 32'(bus.scan_busy), 32'd1);
    collect(0, 0);

    // 4. backpressured scan
    bus.scan_start = 1'b1; tick(); bus.scan_start = 1'b0;
    collect(1, 0);

    // 5. reads and restarts during a scan are dropped
    bus.scan_start = 1'b1; bus.rd_en = 1'b1; bus.rd_addr = 3'd1; bus.rd_ch = 2'd0;
    tick();
    bus.scan_start = 1'b0; bus.rd_en = 1'b0;
    chk("rd_drop_start", 32'(bus.rd_valid), 32'd0);
    collect(2, 0);
    for (int i = 0; i < 4; i++) begin
      chk("no_second_scan", 32'({bus.scan_busy, bus.scan_valid}), 32'd0);
      tick();
    end

    // 6. reset mid-scan aborts, then a fresh scan starts from address 0
    bus.scan_start = 1'b1; tick(); bus.scan_start = 1'b0;
    collect(0, 4);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.scan_busy), 32'd0);
    chk("abort_valid", 32'(bus.scan_valid), 32'd0);
    chk("abort_data", 32'(bus.scan_data), 32'd0);
    chk("abort_sol_last", 32'({bus.scan_sol, bus.scan_last}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(bus.scan_done), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_abort_idle", 32'({bus.scan_busy, bus.scan_done}), 32'd0);
    bus.scan_start = 1'b1; tick(); bus.scan_start = 1'b0;
    collect(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
